// File: rtl/fifo_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_pkg: shared defaults and occupancy-width helper for the FIFO slice
// Revision: 1.0
// ----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  // Occupancy spans 0..DEPTH inclusive, hence one bit more than the pointers.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int COUNT_W_DEF = count_w(DEPTH_DEF);

  typedef logic [COUNT_W_DEF-1:0] count_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_mem: dual-port register array, one write port, one registered read port
// Revision: 1.0
// ----------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule : fifo_mem
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_ctrl: single-clock FIFO with pointers, occupancy and sticky flags
// Revision: 1.0
// ----------------------------------------------------------------------------
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_n,
  input  logic              rd_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              over_flow,
  output logic              under_flow
);

  localparam int CNT_W = count_w(DEPTH);

  logic              wr_req;
  logic              rd_req;
  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]  count_d, count_q;
  logic              over_flow_d, over_flow_q;
  logic              under_flow_d, under_flow_q;

  assign wr_req = !wr_n;
  assign rd_req = !rd_n;
  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);

  // A write into a full FIFO is still legal when a read frees the slot on the same edge.
  assign wr_acc = wr_req && (!full || rd_req);
  assign rd_acc = rd_req && !empty;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    over_flow_d  = over_flow_q;
    under_flow_d = under_flow_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Set takes priority over clear for both sticky flags.
    if (wr_req && full && !rd_req) begin
      over_flow_d = 1'b1;
    end else if (rd_acc) begin
      over_flow_d = 1'b0;
    end

    if (rd_req && empty && !wr_req) begin
      under_flow_d = 1'b1;
    end else if (wr_acc) begin
      under_flow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      over_flow_q  <= 1'b0;
      under_flow_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      over_flow_q  <= over_flow_d;
      under_flow_q <= under_flow_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );

  assign count      = count_q;
  assign over_flow  = over_flow_q;
  assign under_flow = under_flow_q;

endmodule : fifo_ctrl
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fifo_ctrl: directed self-checking bench for fifo_ctrl
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       wr_n;
  logic       rd_n;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  count_t     count;
  logic       over_flow;
  logic       under_flow;

  int errors = 0;
  int checks = 0;

  fifo_ctrl #(
    .DATA_W (8),
    .DEPTH  (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_n       (wr_n),
    .rd_n       (rd_n),
    .din        (din),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .over_flow  (over_flow),
    .under_flow (under_flow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    wr_n = w;
    rd_n = r;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int c, input logic f, input logic e,
                           input logic ovf, input logic udf);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".over_flow"}, 32'(over_flow), 32'(ovf));
    chk({tag, ".under_flow"}, 32'(under_flow), 32'(udf));
  endtask

  initial begin
    rst_n = 1'b1;
    wr_n  = 1'b1;
    rd_n  = 1'b1;
    din   = 8'h00;
    #1;
    rst_n = 1'b0;

    // Reset held for three edges with a write request pending.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'hEE);
    chk_state("in_reset", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("in_reset.dout", 32'(dout), 32'h00);
    rst_n = 1'b1;
    cyc(1'b1, 1'b1, 8'h00);
    chk_state("post_reset", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Fill with 0x00..0x0F, then a 17th write of 0x10 is rejected.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'(i));
      chk("fill.count", 32'(count), 32'(i + 1));
      chk("fill.full", 32'(full), (i == 15) ? 32'd1 : 32'd0);
      chk("fill.over_flow", 32'(over_flow), 32'd0);
    end
    cyc(1'b0, 1'b1, 8'h10);
    chk_state("overflow", 16, 1'b1, 1'b0, 1'b1, 1'b0);

    // Drain 16 entries: data in order, 0x10 never appears.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'h00);
      chk("drain.dout", 32'(dout), 32'(i));
      chk("drain.count", 32'(count), 32'(15 - i));
      chk("drain.over_flow", 32'(over_flow), 32'd0);
      chk("drain.empty", 32'(empty), (i == 15) ? 32'd1 : 32'd0);
      chk("drain.under_flow", 32'(under_flow), 32'd0);
    end
    cyc(1'b1, 1'b0, 8'h00);
    chk_state("underflow", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("underflow.dout_held", 32'(dout), 32'h0F);

    // Simultaneous read/write at empty: only the write takes effect.
    cyc(1'b0, 1'b0, 8'hA5);
    chk_state("rw_empty", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rw_empty.dout_held", 32'(dout), 32'h0F);
    cyc(1'b1, 1'b0, 8'h00);
    chk("rw_empty.readback", 32'(dout), 32'hA5);
    chk("rw_empty.count0", 32'(count), 32'd0);

    // Simultaneous read/write at count=5.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h20 + i));
    chk("rw5.pre_count", 32'(count), 32'd5);
    cyc(1'b0, 1'b0, 8'h25);
    chk("rw5.count", 32'(count), 32'd5);
    chk("rw5.dout", 32'(dout), 32'h20);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 8'h00);
      chk("rw5.drain", 32'(dout), 32'(8'h21 + i));
    end
    chk("rw5.empty", 32'(empty), 32'd1);

    // Simultaneous read/write at full.
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(8'h30 + i));
    chk("rwfull.pre_full", 32'(full), 32'd1);
    cyc(1'b0, 1'b0, 8'h40);
    chk_state("rwfull", 16, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rwfull.dout", 32'(dout), 32'h30);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'h00);
      chk("rwfull.drain", 32'(dout), 32'(8'h31 + i));
    end
    chk_state("rwfull.end", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Pointer wrap: 40 writes and 40 reads with occupancy held at 1.
    cyc(1'b0, 1'b1, 8'h50);
    for (int i = 1; i < 40; i++) begin
      cyc(1'b0, 1'b0, 8'(8'h50 + i));
      chk("wrap.dout", 32'(dout), 32'(8'h50 + i - 1));
      chk("wrap.count", 32'(count), 32'd1);
    end
    cyc(1'b1, 1'b0, 8'h00);
    chk("wrap.last", 32'(dout), 32'h77);
    chk_state("wrap.end", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a write burst at count=9.
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 8'(8'h80 + i));
    chk("async.pre_count", 32'(count), 32'd9);
    wr_n = 1'b0;
    din  = 8'h89;
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("async.dout", 32'(dout), 32'h00);
    @(posedge clk);
    #1;
    chk("async.held", 32'(count), 32'd0);
    rst_n = 1'b1;
    cyc(1'b1, 1'b1, 8'h00);
    chk_state("async.release", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fifo_ctrl
`default_nettype wire
